a2d_spi_resp: RTL and testbench
===============================

A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named clk and rst_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 SS_n  input  1  serf select from the SPI initiator; active low; asynchronous to clk.
REQ-005 SCLK  input  1  SPI clock from the initiator; idles high; asynchronous to clk.
REQ-006 MOSI  input  1  command data from the initiator; valid at SCLK rise.
REQ-007 MISO  output  1  response data to the initiator; changes after SCLK fall.
REQ-008 chan  output  3  channel number from the last accepted command.
REQ-009 chan_val  input  12  conversion value for the channel on chan; sampled when smpl=1.
REQ-010 smpl  output  1  one-clk pulse; chan_val is captured into the result register in the same cycle.
REQ-011 cmd_err  output  1  one-clk pulse on a rejected or malformed frame.

Function
REQ-012 SS_n, SCLK and MOSI SHALL each pass through two flops, plus a third flop on SS_n and SCLK for edge detection; all internal logic SHALL use only the synchronized versions.
REQ-013 The FSM SHALL have three states: IDLE (SS_n high), SHIFT (frame active) and LATCH (one cycle after SS_n rise).
REQ-014 In IDLE, a synced SS_n fall SHALL load tx_shft with {4'h0, result}, clear bit_cnt (5 bits) and rx_shft, and move the FSM to SHIFT.
REQ-015 In SHIFT, each synced SCLK rise SHALL shift MOSI into the LSB of rx_shft and increment bit_cnt; bit_cnt saturates at 31.
REQ-016 In SHIFT, each synced SCLK fall with bit_cnt>0 SHALL shift tx_shft left by one and fill the LSB with 0; a fall with bit_cnt==0 (front porch) SHALL leave tx_shft unchanged.
REQ-017 MISO SHALL equal tx_shft[15] whenever the FSM is in SHIFT, and 0 otherwise.
REQ-018 A synced SS_n rise in SHIFT SHALL move the FSM to LATCH; LATCH SHALL return to IDLE after one cycle.
REQ-019 In LATCH with bit_cnt==16 and the command accepted, chan SHALL be set to rx_shft[13:11] and smpl SHALL pulse in the next cycle, capturing chan_val into result (12 bits).
REQ-020 In LATCH with bit_cnt!=16, cmd_err SHALL pulse, and chan and result SHALL hold their values.
REQ-021 Every frame's response SHALL be the result of the most recent accepted command, so a command frame followed by a read frame returns the requested channel.
REQ-022 An SS_n fall arriving during LATCH or the smpl cycle SHALL be honoured; the FSM SHALL not miss a frame that starts 2 or more clks after SS_n rise.
REQ-023 When synced SCLK rise and SS_n rise are detected in the same cycle, the SCLK rise SHALL be processed first.
REQ-024 SS_n rising while bit_cnt==0 (an empty frame) SHALL produce cmd_err and SHALL NOT produce smpl.

Reset
REQ-025 On reset: FSM=IDLE; tx_shft, rx_shft, bit_cnt and result = 0; chan=3'b000; MISO=0; smpl=0; cmd_err=0; synchronizer flops for SS_n and SCLK preset to 1, for MOSI cleared to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release, the FSM SHALL wait in IDLE for a fresh SS_n fall.

Configuration
REQ-027 Macro A2D_RESP_CMD_CHK_EN, when defined: a 16-bit frame with rx_shft[15:14]!=2'b00 or rx_shft[10:0]!=0 SHALL be rejected (cmd_err pulse, no smpl, chan and result unchanged).
REQ-028 Without A2D_RESP_CMD_CHK_EN: every 16-bit frame SHALL be accepted, its payload bits ignored, and cmd_err SHALL pulse only for bit-count errors.

Verification
REQ-029 Command frame 16'h1800 (ch 3) with chan_val=12'hA5C -> chan=3, smpl pulses once; the next frame with MOSI=16'h0000 returns 16'h0A5C on MISO.
REQ-030 First frame after reset -> MISO returns 16'h0000; chan=0.
REQ-031 Back-to-back commands for ch 0, 1, 3, 4 with distinct chan_val values -> each following frame returns the prior command's value; chan sequence is 0,1,3,4.
REQ-032 Frame aborted after 9 SCLK cycles -> cmd_err pulses once; no smpl; chan and result unchanged.
REQ-033 With A2D_RESP_CMD_CHK_EN defined, frame 16'hC800 -> cmd_err pulses and chan is unchanged; without the macro, the same frame -> chan=1 and smpl pulses.
REQ-034 rst_n asserted at bit 7 of a frame -> all outputs go to reset values at once; the next full frame behaves as in REQ-030.

Source files
------------

// File: rtl/a2d_spi_resp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// a2d_spi_resp
//
// SPI responder for a multi-channel A2D front end.
// A 16-bit command frame selects a channel on chan. One clk later, smpl pulses
// and chan_val is captured into a 12-bit result register. The next frame
// returns that result on MISO as {4'h0, result}, most significant bit first.
// Frames whose bit count is not exactly 16 are dropped with a one-clk cmd_err
// pulse.
//
// The SPI pins are asynchronous to clk. They are synchronized and edge
// detected, and all decisions are made in the clk domain. SCLK idles high.
// MOSI is sampled on SCLK rise and MISO advances on SCLK fall. The first fall
// of a frame is a front porch and does not advance MISO.
//
// Optional feature, macro A2D_RESP_CMD_CHK_EN:
//   When this macro is defined, a 16-bit frame is rejected unless
//   rx[15:14]==2'b00 and rx[10:0]==0. A rejected frame gives cmd_err, no smpl,
//   and chan/result unchanged.
//   When it is not defined, every 16-bit frame is accepted and only
//   rx[13:11] is used.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   SS_n      in   1   serf select, active low, asynchronous to clk
//   SCLK      in   1   SPI clock, idles high, asynchronous to clk
//   MOSI      in   1   command data, valid at SCLK rise
//   MISO      out  1   response data, changes after SCLK fall
//   chan      out  3   channel from the last accepted command
//   chan_val  in   12  conversion value for chan, captured while smpl=1
//   smpl      out  1   one-clk pulse, result <= chan_val in that cycle
//   cmd_err   out  1   one-clk pulse on a rejected or malformed frame
// -----------------------------------------------------------------------------
module a2d_spi_resp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic [2:0]  chan,
    input  logic [11:0] chan_val,
    output logic        smpl,
    output logic        cmd_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [4:0] CNT_MAX    = 5'd31;

    state_t      state;
    logic [15:0] tx_shft;
    logic [15:0] rx_shft;
    logic [4:0]  bit_cnt;
    logic [11:0] result;

    // Synchronizer chains. The third stage on SS_n and SCLK is the edge
    // detector's history bit.
    logic ss_n_ff1, ss_n_ff2, ss_n_ff3;
    logic sclk_ff1, sclk_ff2, sclk_ff3;
    logic mosi_ff1, mosi_ff2;

    logic ss_fall, ss_rise;
    logic sclk_fall, sclk_rise;
    logic cmd_ok;
    logic [15:0] load_word;

    // NOTE: SS_n and SCLK chains preset to their idle level (1) so that
    // releasing reset never fabricates an edge on an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_ff1 <= 1'b1;
            ss_n_ff2 <= 1'b1;
            ss_n_ff3 <= 1'b1;
            sclk_ff1 <= 1'b1;
            sclk_ff2 <= 1'b1;
            sclk_ff3 <= 1'b1;
            mosi_ff1 <= 1'b0;
            mosi_ff2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's
            // value from before this edge; blocking would collapse the chain.
            ss_n_ff1 <= SS_n;
            ss_n_ff2 <= ss_n_ff1;
            ss_n_ff3 <= ss_n_ff2;
            sclk_ff1 <= SCLK;
            sclk_ff2 <= sclk_ff1;
            sclk_ff3 <= sclk_ff2;
            mosi_ff1 <= MOSI;
            mosi_ff2 <= mosi_ff1;
        end
    end

    assign ss_fall   =  ss_n_ff3 & ~ss_n_ff2;
    assign ss_rise   = ~ss_n_ff3 &  ss_n_ff2;
    assign sclk_fall =  sclk_ff3 & ~sclk_ff2;
    assign sclk_rise = ~sclk_ff3 &  sclk_ff2;

`ifdef A2D_RESP_CMD_CHK_EN
    assign cmd_ok = (rx_shft[15:14] == 2'b00) && (rx_shft[10:0] == 11'd0);
`else
    // Payload bits outside the channel field are ignored in this build.
    logic unused_payload;
    assign unused_payload = ^{rx_shft[15:14], rx_shft[10:0]};
    assign cmd_ok = 1'b1;
`endif

    // A frame may start while smpl is high, before result has taken
    // chan_val. In that case, load the value that is being captured so the
    // response is always from the most recent accepted command.
    assign load_word = smpl ? {4'h0, chan_val} : {4'h0, result};

    assign MISO = (state == SHIFT) & tx_shft[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_shft <= 16'h0000;
            rx_shft <= 16'h0000;
            bit_cnt <= 5'd0;
            result  <= 12'h000;
            chan    <= 3'b000;
            smpl    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            smpl    <= 1'b0;
            cmd_err <= 1'b0;

            if (smpl) begin
                result <= chan_val;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_shft <= load_word;
                        rx_shft <= 16'h0000;
                        bit_cnt <= 5'd0;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    // The SCLK rise is applied in the same cycle as an SS_n
                    // rise, so LATCH sees the final bit count and data.
                    if (sclk_rise) begin
                        rx_shft <= {rx_shft[14:0], mosi_ff2};
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    if (sclk_fall && (bit_cnt != 5'd0)) begin
                        tx_shft <= {tx_shft[14:0], 1'b0};
                    end else if (smpl && (bit_cnt == 5'd0)) begin
                        // The frame began in LATCH, before the new result
                        // existed. Refresh it while nothing has been shifted.
                        tx_shft <= {4'h0, chan_val};
                    end

                    if (ss_rise) begin
                        state <= LATCH;
                    end
                end

                LATCH: begin
                    if ((bit_cnt == FRAME_BITS) && cmd_ok) begin
                        chan <= rx_shft[13:11];
                        smpl <= 1'b1;
                    end else begin
                        cmd_err <= 1'b1;
                    end

                    if (ss_fall) begin
                        tx_shft <= load_word;
                        rx_shft <= 16'h0000;
                        bit_cnt <= 5'd0;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end

                // NOTE: recovers from the unused encoding and keeps the case
                // complete so no latch or stuck state can arise.
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
`timescale 1ns/1ps
// Testbench for a2d_spi_resp.
// A reference model of the command and response protocol pushes the expected
// MISO words and smpl/cmd_err events into queues. Independent monitors pop
// from these queues and compare whenever the DUT presents the matching output.
module tb_a2d_spi_resp;

    localparam int H = 6;   // SPI half period in clk cycles

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n  = 1'b1;
    logic        SCLK  = 1'b1;
    logic        MOSI  = 1'b0;
    logic        MISO;
    logic [2:0]  chan;
    logic [11:0] chan_val;
    logic        smpl;
    logic        cmd_err;

    logic [11:0] val_tbl [8];
    assign chan_val = val_tbl[chan];

    a2d_spi_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .chan     (chan),
        .chan_val (chan_val),
        .smpl     (smpl),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [2:0] chan;
    } evt_t;

    evt_t        exp_evt_q  [$];
    logic [15:0] exp_miso_q [$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the responder should hold.
    logic [11:0] model_result = 12'h000;
    logic [2:0]  model_chan   = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit cmd_ok(input logic [15:0] c);
`ifdef A2D_RESP_CMD_CHK_EN
        return (c[15:14] == 2'b00) && (c[10:0] == 11'd0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] ch_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'd0};
    endfunction

    // Initiator side of the bus: SCLK idles high, MOSI changes on the fall.
    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int gap);
        SS_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            wait_clk(H);
            SCLK = 1'b1;
            wait_clk(H);
        end
        wait_clk(H);
        SS_n = 1'b1;
        MOSI = 1'b0;
        wait_clk(gap);
    endtask

    // Record the expected outcome of one frame, then drive the frame.
    task automatic issue(input logic [15:0] cmd, input int nbits, input int gap);
        evt_t e;
        if (nbits == 16) begin
            exp_miso_q.push_back({4'h0, model_result});
            if (cmd_ok(cmd)) begin
                model_chan   = cmd[13:11];
                model_result = val_tbl[model_chan];
                e.is_err     = 1'b0;
            end else begin
                e.is_err = 1'b1;
            end
        end else begin
            e.is_err = 1'b1;
        end
        e.chan = model_chan;
        exp_evt_q.push_back(e);
        spi_frame(cmd, nbits, gap);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_evt_q.size() != 0 || exp_miso_q.size() != 0) && n < 200) begin
            wait_clk(1);
            n++;
        end
        check(name, 32'(exp_evt_q.size() + exp_miso_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},    32'(MISO),    32'd0);
        check({tag, "_chan"},    32'(chan),    32'd0);
        check({tag, "_smpl"},    32'(smpl),    32'd0);
        check({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
    endtask

    // Monitor: gather MISO at each SCLK rise in a frame and compare full
    // 16-bit frames with the expected response.
    initial begin : miso_mon
        int          nb;
        logic [15:0] w;
        logic [15:0] exp_w;
        forever begin
            @(negedge SS_n);
            nb = 0;
            w  = 16'h0000;
            while (SS_n == 1'b0) begin
                @(posedge SCLK or posedge SS_n);
                if (SS_n == 1'b0 && SCLK == 1'b1) begin
                    w = {w[14:0], MISO};
                    nb++;
                end
            end
            if (nb == 16) begin
                if (exp_miso_q.size() == 0) begin
                    check("miso_unexpected_frame", 32'(w), 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_miso_q.pop_front();
                    check("miso_word", 32'(w), 32'(exp_w));
                end
            end
        end
    end

    // Monitor: each smpl or cmd_err pulse consumes one expected event.
    initial begin : evt_mon
        evt_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (smpl === 1'b1 || cmd_err === 1'b1)) begin
                if (exp_evt_q.size() == 0) begin
                    check("evt_unexpected", {30'd0, smpl, cmd_err}, 32'd0);
                end else begin
                    e = exp_evt_q.pop_front();
                    check("evt_kind", {30'd0, smpl, cmd_err}, e.is_err ? 32'd1 : 32'd2);
                    check("evt_chan", 32'(chan), 32'(e.chan));
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] cmd;
        int          nbits;
        int          r;

        for (int i = 0; i < 8; i++) val_tbl[i] = 12'($urandom);

        // Reset state.
        wait_clk(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clk(5);

        // First frame after reset returns zero and selects channel 0.
        issue(16'h0000, 16, 20);
        check("first_chan", 32'(chan), 32'd0);

        // Channel 3 command, then a read frame returns its value.
        drain("drain_a");
        val_tbl[3] = 12'hA5C;
        issue(16'h1800, 16, 20);
        check("cmd3_chan", 32'(chan), 32'd3);
        issue(16'h0000, 16, 20);

        // Back-to-back commands with the minimum SS_n high time.
        drain("drain_b");
        val_tbl[0] = 12'h111;
        val_tbl[1] = 12'h222;
        val_tbl[3] = 12'h333;
        val_tbl[4] = 12'h444;
        issue(ch_cmd(3'd0), 16, 2);
        issue(ch_cmd(3'd1), 16, 2);
        issue(ch_cmd(3'd3), 16, 3);
        issue(ch_cmd(3'd4), 16, 2);
        issue(ch_cmd(3'd4), 16, 20);

        // Aborted, empty, and overlong frames.
        issue(16'h2800, 9, 20);
        issue(16'h0000, 0, 20);
        issue(16'h0000, 35, 20);
        check("bad_frames_chan", 32'(chan), 32'd4);

        // Payload check frame; the result depends on the build option.
        issue(16'hC800, 16, 20);
        issue(16'h0000, 16, 20);

        // Reset in the middle of a frame, with chan and result nonzero.
        drain("drain_c");
        val_tbl[5] = 12'h5A5;
        issue(ch_cmd(3'd5), 16, 20);
        drain("drain_d");
        SS_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 7; i++) begin
            SCLK = 1'b0;
            MOSI = 1'($urandom_range(0, 1));
            wait_clk(H);
            SCLK = 1'b1;
            wait_clk(H);
        end
        SCLK = 1'b0;
        wait_clk(H);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        SS_n = 1'b1;
        wait_clk(1);
        SCLK = 1'b1;
        MOSI = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        model_result = 12'h000;
        model_chan   = 3'b000;
        wait_clk(10);
        issue(16'h0000, 16, 20);
        check("post_reset_chan", 32'(chan), 32'd0);

        // Randomized frames.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                drain("drain_rand");
                val_tbl[$urandom_range(0, 7)] = 12'($urandom);
            end
            cmd = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : ch_cmd(3'($urandom_range(0, 7)));
            r = $urandom_range(0, 9);
            if (r < 8)       nbits = 16;
            else if (r == 8) nbits = $urandom_range(0, 15);
            else             nbits = $urandom_range(17, 34);
            issue(cmd, nbits, $urandom_range(2, 12));
        end

        drain("final_drain");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
